alu_nibble_serial_sub: RTL and testbench

- Multi-cycle subtractor; the inverse-direction companion to the ALU's carry-lookahead adder stage.
- Computes A - B - borrow, 4 bits per clock, least significant nibble first, with a registered borrow chain between nibbles.
- Borrow-in and borrow-out are active-low, matching the adder's active-low carry convention.
- Sits beside the ALU adder datapath and serves area-constrained subtract/compare operations behind a start/done handshake.

---
 rtl/alu_nibble_serial_sub.sv | 191 +++++++++++++++++++
 tb/tb_alu_nibble_serial_sub.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_serial_sub.sv
// Nibble-serial subtractor: D = A - B - borrow, 4 bits per clock, LSB nibble first,
// active-low borrow in/out. Define SUB_OVF_EN to enable the signed-overflow flag V.
module alu_nibble_serial_sub #(
    parameter int WIDTH   = 16,
    parameter int NIBBLES = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst_inverse,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bi_inverse,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bo_inverse,
    output logic             Z,
    output logic             V
);

    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Result bit 4 is the borrow out (set when the nibble difference went negative).
    function automatic logic [4:0] sub_nibble(input logic [3:0] a_nib,
                                              input logic [3:0] b_nib,
                                              input logic       b_in);
        sub_nibble = {1'b0, a_nib} - {1'b0, b_nib} - {4'b0000, b_in};
    endfunction

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               borrow_q, borrow_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               bo_q, bo_d;
    logic               z_q, z_d;
    logic               v_q, v_d;

    logic [4:0]         nib_res_s;
    logic [WIDTH-1:0]   d_next_s;
    logic               last_s;

    // State register.
    always_ff @(posedge clk or negedge rst_inverse) begin
        if (!rst_inverse) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Current-nibble arithmetic and the full D value it produces.
    always_comb begin
        nib_res_s = sub_nibble(a_q[cnt_q*4 +: 4], b_q[cnt_q*4 +: 4], borrow_q);
        d_next_s  = d_q;
        d_next_s[cnt_q*4 +: 4] = nib_res_s[3:0];
        last_s    = (cnt_q == LAST_NIB);
    end

    // Output and datapath next values.
    always_comb begin
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        borrow_d = borrow_q;
        d_d      = d_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        bo_d     = bo_q;
        z_d      = z_q;
        v_d      = v_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    borrow_d = ~Bi_inverse;
                    cnt_d    = {CNT_W{1'b0}};
                    busy_d   = 1'b1;
                end else begin
                    busy_d   = 1'b0;
                end
            end
            ST_RUN: begin
                d_d      = d_next_s;
                borrow_d = nib_res_s[4];
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_s) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    bo_d   = ~nib_res_s[4];
                    z_d    = (d_next_s == {WIDTH{1'b0}});
                    v_d    = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                             (d_next_s[WIDTH-1] != a_q[WIDTH-1]);
                end else begin
                    busy_d = 1'b1;
                end
            end
            ST_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_inverse) begin
        if (!rst_inverse) begin
            cnt_q    <= {CNT_W{1'b0}};
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            borrow_q <= 1'b0;
            d_q      <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            bo_q     <= 1'b1;
            z_q      <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            borrow_q <= borrow_d;
            d_q      <= d_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            bo_q     <= bo_d;
            z_q      <= z_d;
        end
    end

`ifdef SUB_OVF_EN
    // Overflow flag register, updated only on the final nibble.
    always_ff @(posedge clk or negedge rst_inverse) begin
        if (!rst_inverse) begin
            v_q <= 1'b0;
        end else begin
            v_q <= v_d;
        end
    end
`else
    // With overflow disabled the flag is a constant; v_d is left unused.
    assign v_q = 1'b0;
    logic unused_v_s;
    assign unused_v_s = v_d;
`endif

    assign busy       = busy_q;
    assign done       = done_q;
    assign D          = d_q;
    assign Bo_inverse = bo_q;
    assign Z          = z_q;
    assign V          = v_q;

endmodule

// File: tb/tb_alu_nibble_serial_sub.sv
// Directed self-checking bench for alu_nibble_serial_sub (WIDTH=16).
module tb_alu_nibble_serial_sub;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_inverse;
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Bi_inverse;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             Bo_inverse;
    logic             Z;
    logic             V;

    int checks_r;
    int failures_r;

    alu_nibble_serial_sub #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_inverse(rst_inverse),
        .start      (start),
        .A          (A),
        .B          (B),
        .Bi_inverse (Bi_inverse),
        .busy       (busy),
        .done       (done),
        .D          (D),
        .Bo_inverse (Bo_inverse),
        .Z          (Z),
        .V          (V)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (obs !== exp) begin
            failures_r = failures_r + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic ovf_exp(input logic v_when_enabled);
`ifdef SUB_OVF_EN
        ovf_exp = v_when_enabled;
`else
        ovf_exp = 1'b0 & v_when_enabled;
`endif
    endfunction

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
        check_val({tag, "_done"}, 32'(done), 32'd0);
        check_val({tag, "_D"}, 32'(D), 32'h0000);
        check_val({tag, "_Bo"}, 32'(Bo_inverse), 32'd1);
        check_val({tag, "_Z"}, 32'(Z), 32'd0);
        check_val({tag, "_V"}, 32'(V), 32'd0);
    endtask

    // One full operation; called at posedge+1 with DUT in IDLE.
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic bi, input logic [15:0] exp_d, input logic exp_bo,
                          input logic exp_z, input logic v_en);
        A = a; B = b; Bi_inverse = bi; start = 1'b1;
        step();
        start = 1'b0;
        A = 16'hA5A5; B = 16'h5A5A; Bi_inverse = ~bi;
        check_val({tag, "_busy0"}, 32'(busy), 32'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            check_val({tag, "_busyrun"}, 32'(busy), 32'd1);
            check_val({tag, "_nodone"}, 32'(done), 32'd0);
        end
        step();
        check_val({tag, "_done"}, 32'(done), 32'd1);
        check_val({tag, "_busyend"}, 32'(busy), 32'd0);
        check_val({tag, "_D"}, 32'(D), 32'(exp_d));
        check_val({tag, "_Bo"}, 32'(Bo_inverse), 32'(exp_bo));
        check_val({tag, "_Z"}, 32'(Z), 32'(exp_z));
        check_val({tag, "_V"}, 32'(V), 32'(ovf_exp(v_en)));
        step();
        check_val({tag, "_donepulse"}, 32'(done), 32'd0);
        check_val({tag, "_Dhold"}, 32'(D), 32'(exp_d));
    endtask

    initial begin
        int done_seen;
        checks_r = 0;
        failures_r = 0;
        start = 1'b0;
        A = 16'h0000;
        B = 16'h0000;
        Bi_inverse = 1'b1;
        rst_inverse = 1'b0;
        #12;
        check_reset_outputs("reset");
        rst_inverse = 1'b1;
        step();

        run_op("basic",   16'h1234, 16'h0034, 1'b1, 16'h1200, 1'b1, 1'b0, 1'b0);
        run_op("wrap",    16'h0000, 16'h0001, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_op("zero",    16'h5555, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b0);
        run_op("bin",     16'h0010, 16'h0000, 1'b0, 16'h000F, 1'b1, 1'b0, 1'b0);
        run_op("bin_eq",  16'h00FF, 16'h00FF, 1'b0, 16'hFFFF, 1'b0, 1'b0, 1'b0);
        run_op("ovf",     16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b0, 1'b1);
        run_op("noovf",   16'h0003, 16'h0001, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0);

        // start held high: operands captured only on IDLE edges, done every 6 cycles
        A = 16'h0100; B = 16'h0001; Bi_inverse = 1'b1; start = 1'b1;
        step();
        A = 16'hFFFF; B = 16'hFFFF;
        done_seen = 0;
        for (int i = 1; i < 4; i++) begin
            step();
            if (done) done_seen++;
        end
        check_val("hold_early_done", 32'(done_seen), 32'd0);
        step();
        check_val("hold_done1", 32'(done), 32'd1);
        check_val("hold_D1", 32'(D), 32'h00FF);
        A = 16'h0009; B = 16'h0004;
        step();
        check_val("hold_idle_busy", 32'(busy), 32'd0);
        check_val("hold_idle_done", 32'(done), 32'd0);
        step();
        check_val("hold_restart_busy", 32'(busy), 32'd1);
        A = 16'h7777; B = 16'h1111;
        done_seen = 0;
        for (int i = 1; i < 4; i++) begin
            step();
            if (done) done_seen++;
        end
        check_val("hold_gap_done", 32'(done_seen), 32'd0);
        step();
        check_val("hold_done2", 32'(done), 32'd1);
        check_val("hold_D2", 32'(D), 32'h0005);
        start = 1'b0;
        step();

        // reset during the second RUN cycle abandons the operation
        A = 16'h4321; B = 16'h0021; Bi_inverse = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step();
        #2;
        rst_inverse = 1'b0;
        #1;
        check_reset_outputs("midrst");
        #1;
        rst_inverse = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 7; i++) begin
            step();
            if (done) done_seen++;
        end
        check_val("midrst_nodone", 32'(done_seen), 32'd0);
        check_val("midrst_idle_busy", 32'(busy), 32'd0);
        run_op("after_rst", 16'h4321, 16'h0021, 1'b1, 16'h4300, 1'b1, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
